// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch time base: FSM state codes, counter limits
// and the decimal-point decode used by the controller.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [6:0] MSEC_MAX  = 7'd99;
    localparam logic [5:0] SEC_MAX   = 6'd59;
    localparam logic [5:0] MIN_MAX   = 6'd59;
    localparam logic [6:0] DP_THRESH = 7'd50;

    // Blink in RUN (first half second lit), steady in PAUSE, dark otherwise.
    function automatic logic dp_decode(input state_e state, input logic [6:0] msec);
        logic dp;
        case (state)
            ST_RUN:   dp = (msec < DP_THRESH);
            ST_PAUSE: dp = 1'b1;
            default:  dp = 1'b0;
        endcase
        return dp;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to one tick every DIV enabled cycles; the partial
// period is kept while disabled and discarded only by an explicit clear.
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          tick_s;

    assign tick_s = i_en && !i_clr && (cnt_r >= LAST);

    // Next prescaler count: clear has priority, then count while enabled, else hold.
    always_comb begin
        cnt_next_s = cnt_r;
        if (i_clr) begin
            cnt_next_s = '0;
        end else if (i_en) begin
            if (cnt_r >= LAST) begin
                cnt_next_s = '0;
            end else begin
                cnt_next_s = cnt_r + 1'b1;
            end
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Prescaler count register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign o_tick = tick_s;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller for the FND stopwatch: 3-state FSM, centisecond
// prescaler, cascaded msec/sec/min counters, blinking decimal point and wrap pulse.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_run_stop,
    input  logic       i_clear,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic       o_dp,
    output logic [1:0] o_state,
    output logic       o_wrap
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

    state_e     state_r;
    state_e     state_next_s;
    logic       clear_s;
    logic       tick_s;
    logic       run_s;
    logic       pre_clr_s;
    logic [6:0] msec_r;
    logic [6:0] msec_next_s;
    logic [5:0] sec_r;
    logic [5:0] sec_next_s;
    logic [5:0] min_r;
    logic [5:0] min_next_s;
    logic       msec_carry_s;
    logic       sec_carry_s;
    logic       wrap_next_s;
    logic       dp_r;
    logic       wrap_r;

    // Command decode: clear beats run_stop outside RUN; RUN only honours run_stop.
    always_comb begin
        state_next_s = state_r;
        clear_s      = 1'b0;
        case (state_r)
            ST_STOP: begin
                if (i_clear) begin
                    clear_s      = 1'b1;
                    state_next_s = ST_STOP;
                end else if (i_run_stop) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_RUN: begin
                if (i_run_stop) begin
                    state_next_s = ST_PAUSE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (i_clear) begin
                    clear_s      = 1'b1;
                    state_next_s = ST_STOP;
                end else if (i_run_stop) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
            default: begin
                clear_s      = 1'b1;
                state_next_s = ST_STOP;
            end
        endcase
    end

    assign run_s     = (state_r == ST_RUN);
    assign pre_clr_s = clear_s || (state_r == ST_STOP);

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (run_s),
        .i_clr   (pre_clr_s),
        .o_tick  (tick_s)
    );

    assign msec_carry_s = tick_s && (msec_r == MSEC_MAX);
    assign sec_carry_s  = msec_carry_s && (sec_r == SEC_MAX);

    // Counter cascade; any out-of-range digit reloads zero on the next tick.
    always_comb begin
        msec_next_s = msec_r;
        sec_next_s  = sec_r;
        min_next_s  = min_r;
        wrap_next_s = 1'b0;
        if (state_next_s == ST_STOP) begin
            msec_next_s = 7'd0;
            sec_next_s  = 6'd0;
            min_next_s  = 6'd0;
        end else if (tick_s) begin
            msec_next_s = (msec_r >= MSEC_MAX) ? 7'd0 : msec_r + 7'd1;
            if (sec_r > SEC_MAX) begin
                sec_next_s = 6'd0;
            end else if (msec_carry_s) begin
                sec_next_s = (sec_r == SEC_MAX) ? 6'd0 : sec_r + 6'd1;
            end else begin
                sec_next_s = sec_r;
            end
            if (min_r > MIN_MAX) begin
                min_next_s = 6'd0;
            end else if (sec_carry_s) begin
                min_next_s  = (min_r == MIN_MAX) ? 6'd0 : min_r + 6'd1;
                wrap_next_s = (min_r == MIN_MAX);
            end else begin
                min_next_s = min_r;
            end
        end else begin
            msec_next_s = msec_r;
            sec_next_s  = sec_r;
            min_next_s  = min_r;
        end
    end

    // State, counters and output flags; dp is registered from next-state values so
    // it tracks the current state and count with no extra delay.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_STOP;
            msec_r  <= 7'd0;
            sec_r   <= 6'd0;
            min_r   <= 6'd0;
            dp_r    <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            msec_r  <= msec_next_s;
            sec_r   <= sec_next_s;
            min_r   <= min_next_s;
            dp_r    <= dp_decode(state_next_s, msec_next_s);
            wrap_r  <= wrap_next_s;
        end
    end

    assign o_msec  = msec_r;
    assign o_sec   = sec_r;
    assign o_min   = min_r;
    assign o_dp    = dp_r;
    assign o_state = state_r;
    assign o_wrap  = wrap_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at DIV=10: command table plus hand-built
// sequences for first-tick latency, blink, pause/resume, wrap and async reset.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rs;
    logic       clr;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] mins;
    logic       dp;
    logic [1:0] state;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic rs;
        logic clr;
        int   st;
        int   msec;
        int   dp;
    } vec_t;

    vec_t vecs[10];

    stopwatch_ctrl #(
        .CLK_FREQ_HZ (1000),
        .TICK_HZ     (100)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_run_stop (rs),
        .i_clear    (clr),
        .o_msec     (msec),
        .o_sec      (sec),
        .o_min      (mins),
        .o_dp       (dp),
        .o_state    (state),
        .o_wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int st, input int ms, input int s,
                             input int m, input int d, input int w);
        check({name, ".state"}, int'(state), st);
        check({name, ".msec"}, int'(msec), ms);
        check({name, ".sec"}, int'(sec), s);
        check({name, ".min"}, int'(mins), m);
        check({name, ".dp"}, int'(dp), d);
        check({name, ".wrap"}, int'(wrap), w);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic r, input logic c);
        rs  = r;
        clr = c;
        step(1);
        rs  = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        int bad;
        int exp_ms;

        vecs[0] = '{1'b0, 1'b1, 0, 0, 0};
        vecs[1] = '{1'b1, 1'b1, 0, 0, 0};
        vecs[2] = '{1'b1, 1'b0, 1, 0, 1};
        vecs[3] = '{1'b0, 1'b1, 1, 0, 1};
        vecs[4] = '{1'b1, 1'b1, 2, 0, 1};
        vecs[5] = '{1'b1, 1'b0, 1, 0, 1};
        vecs[6] = '{1'b1, 1'b0, 2, 0, 1};
        vecs[7] = '{1'b0, 1'b0, 2, 0, 1};
        vecs[8] = '{1'b0, 1'b1, 0, 0, 0};
        vecs[9] = '{1'b0, 1'b0, 0, 0, 0};

        rst = 1'b1;
        rs  = 1'b0;
        clr = 1'b0;
        step(3);
        rst = 1'b0;
        step(50);
        check_all("reset_idle", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            pulse(vecs[i].rs, vecs[i].clr);
            check($sformatf("vec%0d.state", i), int'(state), vecs[i].st);
            check($sformatf("vec%0d.msec", i), int'(msec), vecs[i].msec);
            check($sformatf("vec%0d.dp", i), int'(dp), vecs[i].dp);
        end

        // first tick exactly DIV cycles after entering RUN, then blink trace
        pulse(1'b1, 1'b0);
        check("run_entry.state", int'(state), 1);
        step(9);
        check("first_tick_early.msec", int'(msec), 0);
        step(1);
        check("first_tick.msec", int'(msec), 1);
        bad = 0;
        for (int k = 11; k <= 510; k++) begin
            step(1);
            exp_ms = k / 10;
            if (int'(msec) != exp_ms || int'(dp) != ((exp_ms < 50) ? 1 : 0)) bad++;
        end
        check("blink_trace_errors", bad, 0);
        check("after_510.msec", int'(msec), 51);
        check("after_510.dp", int'(dp), 0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check_all("pause_clear", 0, 0, 0, 0, 0, 0);

        // pause with partial prescaler period, resume keeps it
        pulse(1'b1, 1'b0);
        step(34);
        check("pre_pause.msec", int'(msec), 3);
        pulse(1'b1, 1'b0);
        check_all("paused", 2, 3, 0, 0, 1, 0);
        step(100);
        check_all("paused_100", 2, 3, 0, 0, 1, 0);
        pulse(1'b1, 1'b0);
        step(4);
        check("resume_4.msec", int'(msec), 3);
        step(1);
        check("resume_5.msec", int'(msec), 4);
        pulse(1'b0, 1'b1);
        check("run_clear_ignored.state", int'(state), 1);
        check("run_clear_ignored.msec", int'(msec), 4);

        // preload 59:59.98 while paused, then run through the full wrap
        pulse(1'b1, 1'b0);
        force dut.msec_r = 7'd98;
        force dut.sec_r  = 6'd59;
        force dut.min_r  = 6'd59;
        step(1);
        release dut.msec_r;
        release dut.sec_r;
        release dut.min_r;
        step(1);
        check_all("preload", 2, 98, 59, 59, 1, 0);
        pulse(1'b1, 1'b0);
        step(7);
        check("pre_wrap_98.msec", int'(msec), 98);
        step(1);
        check_all("at_59_59_99", 1, 99, 59, 59, 0, 0);
        step(9);
        check("wrap_not_early", int'(wrap), 0);
        step(1);
        check_all("wrapped", 1, 0, 0, 0, 1, 1);
        step(1);
        check("wrap_one_cycle", int'(wrap), 0);
        check("wrap_still_run", int'(state), 1);

        // clear and run_stop together while paused: clear wins
        step(9);
        check("post_wrap.msec", int'(msec), 1);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        check_all("pause_clear_and_rs", 0, 0, 0, 0, 0, 0);

        // asynchronous reset between edges
        pulse(1'b1, 1'b0);
        step(25);
        check("pre_reset.msec", int'(msec), 2);
        check("pre_reset.dp", int'(dp), 1);
        #3;
        rst = 1'b1;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        step(20);
        check_all("after_reset_idle", 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
